// File: rtl/instr_fetch_reg_if.sv
// Instruction-memory fetch port: request/acknowledge handshake with wait states.
`timescale 1ns/1ps
interface instr_fetch_reg_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [DATA_W-1:0] data;

    modport master (output req, output addr, input ack, input data);
    modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/instr_fetch_reg.sv
// Fetch stage and instruction register: owns the PC, fetches over the imem
// handshake, holds the fetched word and splits it into decode fields.
`timescale 1ns/1ps
module instr_fetch_reg #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     Stall,
    input  logic                     Redirect,
    input  logic [31:0]              RedirectAddr,
    instr_fetch_reg_if.master        imem,
    output logic                     instValid,
    output logic [5:0]               op,
    output logic [4:0]               rs,
    output logic [4:0]               rt,
    output logic [4:0]               rd,
    output logic [4:0]               sa,
    output logic [5:0]               funct,
    output logic [15:0]              immediate,
    output logic                     ExtSel,
    output logic [31:0]              pcOut,
    output logic [31:0]              pcPlus4
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        VALID   = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   pend_q, pend_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [ADDR_W-1:0]   pc4_q, pc4_d;
    logic                req_q, req_d;
    logic                valid_q, valid_d;
    logic                ext_q, ext_d;
    logic [ADDR_W-1:0]   redir_addr;
    logic [OP_W-1:0]     op_d;

    // Branch targets are always word aligned.
    assign redir_addr = RedirectAddr & ~ADDR_W'(3);

    // State register.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus next values of every datapath/output register.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        ir_d    = ir_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem.ack) begin
                    if (Redirect) begin
                        pc_d = redir_addr;
                    end else begin
                        ir_d    = imem.data;
                        state_d = VALID;
                    end
                end else if (Redirect) begin
                    pend_d  = redir_addr;
                    state_d = DISCARD;
                end
            end
            VALID: begin
                if (Redirect) begin
                    pc_d    = redir_addr;
                    state_d = FETCH;
                end else if (!Stall) begin
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = FETCH;
                end
            end
            DISCARD: begin
                // The old request must complete before the new target is issued.
                if (Redirect) begin
                    pend_d = redir_addr;
                end
                if (imem.ack) begin
                    pc_d    = Redirect ? redir_addr : pend_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_d   = (state_d == FETCH) || (state_d == DISCARD);
        valid_d = (state_d == VALID);
        pc4_d   = pc_d + ADDR_W'(4);
        op_d    = ir_d[31:26];
        // Logical immediates are zero extended, everything else sign extended.
        ext_d   = !((op_d == OP_W'(6'h0C)) || (op_d == OP_W'(6'h0D)) ||
                    (op_d == OP_W'(6'h0E)));
    end

    // Datapath and output registers.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            pc_q    <= PC_RESET;
            pend_q  <= '0;
            ir_q    <= '0;
            pc4_q   <= PC_RESET + ADDR_W'(4);
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            ext_q   <= 1'b1;
        end else begin
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            ir_q    <= ir_d;
            pc4_q   <= pc4_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            ext_q   <= ext_d;
        end
    end

    assign imem.req  = req_q;
    assign imem.addr = pc_q;
    assign instValid = valid_q;
    assign op        = ir_q[31:26];
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign sa        = ir_q[10:6];
    assign funct     = ir_q[5:0];
    assign immediate = ir_q[15:0];
    assign ExtSel    = ext_q;
    assign pcOut     = pc_q;
    assign pcPlus4   = pc4_q;
endmodule

// File: tb/tb_instr_fetch_reg.sv
// Self-checking bench for instr_fetch_reg: decode vector table, hand-written
// multi-cycle sequences, and a randomized run against a transaction model.
`timescale 1ns/1ps
module tb_instr_fetch_reg;
    localparam logic [31:0] PC_RST = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        Stall = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectAddr = 32'd0;
    logic        instValid;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sa;
    logic [5:0]  funct;
    logic [15:0] immediate;
    logic        ExtSel;
    logic [31:0] pcOut, pcPlus4;

    instr_fetch_reg_if imem();

    instr_fetch_reg #(.PC_RESET(PC_RST)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .Stall        (Stall),
        .Redirect     (Redirect),
        .RedirectAddr (RedirectAddr),
        .imem         (imem),
        .instValid    (instValid),
        .op           (op),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .sa           (sa),
        .funct        (funct),
        .immediate    (immediate),
        .ExtSel       (ExtSel),
        .pcOut        (pcOut),
        .pcPlus4      (pcPlus4)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] word;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sa;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic        ext;
    } vec_t;

    vec_t        vec [8];
    logic [31:0] mem [64];
    int          tests = 0;
    int          fails = 0;

    // Random-phase model state.
    logic        exp_is_req;
    logic [31:0] exp_a;
    logic [31:0] exp_w;
    logic        drop;
    logic [31:0] tgt;
    logic [31:0] ra;
    logic [31:0] p_keep;
    logic [31:0] w_keep;
    int          n_wait;
    bit          ok;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ext_of(input logic [31:0] w);
        logic [5:0] o;
        o = w[31:26];
        return !((o == 6'h0C) || (o == 6'h0D) || (o == 6'h0E));
    endfunction

    task automatic check_valid(input string name, input logic [31:0] w, input logic [31:0] pc);
        check({name, " valid/req"}, 32'({instValid, imem.req}), 32'd2);
        check({name, " fields"}, {op, rs, rt, rd, sa, funct}, w);
        check({name, " imm"}, 32'(immediate), 32'(w[15:0]));
        check({name, " ExtSel"}, 32'(ExtSel), 32'(ext_of(w)));
        check({name, " pcOut"}, pcOut, pc);
        check({name, " pcPlus4"}, pcPlus4, pc + 32'd4);
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        imem.ack = 1'b0;
        imem.data = 32'd0;
        Stall = 1'b0;
        Redirect = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset req/valid", 32'({imem.req, instValid}), 32'd0);
        check("reset pcOut", pcOut, PC_RST);
        check("reset pcPlus4", pcPlus4, PC_RST + 32'd4);
        check("reset IR", {op, rs, rt, rd, sa, funct}, 32'd0);
        check("reset ExtSel", 32'(ExtSel), 32'd1);
        Reset = 1'b1;
    endtask

    // Advance to the next negedge where a request is visible (bounded).
    task automatic wait_req(output int n, output bit found);
        n = 0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            n++;
            if (imem.req) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check("wait_req timeout", 32'd0, 32'd1);
    endtask

    task automatic fetch(input string name, input logic [31:0] w, input int waits,
                         input logic [31:0] a, output int n);
        bit f;
        wait_req(n, f);
        check({name, " addr"}, imem.addr, a);
        for (int k = 0; k < waits; k++) begin
            @(negedge CLK);
            check({name, " wait req/addr"}, {imem.addr[30:0], imem.req}, {a[30:0], 1'b1});
            check({name, " wait valid"}, 32'(instValid), 32'd0);
        end
        imem.ack = 1'b1;
        imem.data = w;
        @(negedge CLK);
        imem.ack = 1'b0;
        imem.data = $urandom;
        check_valid(name, w, a);
    endtask

    initial begin
        vec[0] = '{32'h2008_0005, 6'h08, 5'd0, 5'd8,  5'd0,  5'd0,  6'h05, 16'h0005, 1'b1};
        vec[1] = '{32'h3421_FFFF, 6'h0D, 5'd1, 5'd1,  5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 1'b0};
        vec[2] = '{32'h2021_FFFF, 6'h08, 5'd1, 5'd1,  5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 1'b1};
        vec[3] = '{32'h3000_1234, 6'h0C, 5'd0, 5'd0,  5'd2,  5'd8,  6'h34, 16'h1234, 1'b0};
        vec[4] = '{32'h3800_0000, 6'h0E, 5'd0, 5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 1'b0};
        vec[5] = '{32'h3C00_0000, 6'h0F, 5'd0, 5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 1'b1};
        vec[6] = '{32'h012A_4020, 6'h00, 5'd9, 5'd10, 5'd8,  5'd0,  6'h20, 16'h4020, 1'b1};
        vec[7] = '{32'hFFFF_FFFF, 6'h3F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 1'b1};
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            if ($urandom_range(0, 3) == 0) mem[i][31:26] = 6'(6'h0C + 6'($urandom_range(0, 2)));
        end

        // Decode table: sequential fetches with 0..2 wait states each.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            fetch("table", vec[i].word, i % 3, PC_RST + 32'(4 * i), n_wait);
            if (i == 0) check("first fetch latency", 32'(n_wait), 32'd1);
            check("table op", 32'(op), 32'(vec[i].op));
            check("table rs/rt", 32'({rs, rt}), 32'({vec[i].rs, vec[i].rt}));
            check("table rd/sa/funct", 32'({rd, sa, funct}), 32'({vec[i].rd, vec[i].sa, vec[i].funct}));
            check("table imm", 32'(immediate), 32'(vec[i].imm));
            check("table ExtSel", 32'(ExtSel), 32'(vec[i].ext));
        end

        // Stall holds the instruction for three cycles, then fetch continues at +4.
        p_keep = pcOut;
        w_keep = vec[7].word;
        Stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("stall hold valid/req", 32'({instValid, imem.req}), 32'd2);
            check("stall hold pc/IR", {pcOut[15:0], op, rs, rt}, {p_keep[15:0], w_keep[31:16]});
        end
        Stall = 1'b0;
        @(negedge CLK);
        check("stall release addr", imem.addr, p_keep + 32'd4);
        check("stall release req", 32'(imem.req), 32'd1);
        imem.ack = 1'b1;
        imem.data = 32'h2008_0001;
        @(negedge CLK);
        imem.ack = 1'b0;
        check_valid("post stall", 32'h2008_0001, p_keep + 32'd4);

        // Redirect from VALID with unaligned target.
        Redirect = 1'b1;
        RedirectAddr = 32'h0000_0043;
        @(negedge CLK);
        Redirect = 1'b0;
        check("redirect addr", imem.addr, 32'h0000_0040);
        check("redirect req/valid", 32'({imem.req, instValid}), 32'd2);

        // Redirect while the ack is delayed: old address held, stale data dropped.
        Redirect = 1'b1;
        RedirectAddr = 32'h0000_0100;
        @(negedge CLK);
        Redirect = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("discard hold addr", imem.addr, 32'h0000_0040);
            check("discard req/valid", 32'({imem.req, instValid}), 32'd2);
            if (k < 2) @(negedge CLK);
        end
        imem.ack = 1'b1;
        imem.data = 32'h3421_BAD0;
        @(negedge CLK);
        check("after discard addr", imem.addr, 32'h0000_0100);
        check("after discard valid", 32'(instValid), 32'd0);
        imem.data = 32'h2008_0100;
        @(negedge CLK);
        imem.ack = 1'b0;
        check_valid("redirected fetch", 32'h2008_0100, 32'h0000_0100);

        // PC wrap at the top of the address space.
        Redirect = 1'b1;
        RedirectAddr = 32'hFFFF_FFFE;
        @(negedge CLK);
        Redirect = 1'b0;
        check("wrap redirect addr", imem.addr, 32'hFFFF_FFFC);
        imem.ack = 1'b1;
        imem.data = 32'h3800_00AA;
        @(negedge CLK);
        imem.ack = 1'b0;
        check_valid("wrap fetch", 32'h3800_00AA, 32'hFFFF_FFFC);
        check("wrap pcPlus4", pcPlus4, 32'd0);
        @(negedge CLK);
        check("wrap next addr", imem.addr, 32'd0);

        // Reset asserted in a wait state takes effect without a clock edge.
        @(negedge CLK);
        #2 Reset = 1'b0;
        #1 check("async reset req/valid", 32'({imem.req, instValid}), 32'd0);
        @(negedge CLK);
        Reset = 1'b1;
        wait_req(n_wait, ok);
        check("restart addr", imem.addr, PC_RST);
        check("restart latency", 32'(n_wait), 32'd1);

        // Randomized run against a transaction-level model.
        do_reset();
        exp_is_req = 1'b1;
        exp_a = PC_RST;
        exp_w = 32'd0;
        drop = 1'b0;
        tgt = 32'd0;
        @(negedge CLK);
        for (int c = 0; c < 3000; c++) begin
            if (c != 0) @(negedge CLK);
            if (exp_is_req) begin
                check("rand req/valid", 32'({imem.req, instValid}), 32'd2);
                check("rand addr", imem.addr, exp_a);
            end else begin
                check_valid("rand", exp_w, exp_a);
            end
            imem.ack = ($urandom_range(0, 1) == 0);
            imem.data = imem.ack ? mem[imem.addr[7:2]] : $urandom;
            Redirect = ($urandom_range(0, 7) == 0);
            RedirectAddr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            Stall = ($urandom_range(0, 2) == 0);
            ra = {RedirectAddr[31:2], 2'b00};
            if (exp_is_req) begin
                if (Redirect) begin
                    drop = 1'b1;
                    tgt = ra;
                end
                if (imem.ack) begin
                    if (drop) begin
                        exp_a = tgt;
                        drop = 1'b0;
                    end else begin
                        exp_is_req = 1'b0;
                        exp_w = mem[exp_a[7:2]];
                    end
                end
            end else begin
                if (Redirect) begin
                    exp_is_req = 1'b1;
                    exp_a = ra;
                end else if (!Stall) begin
                    exp_is_req = 1'b1;
                    exp_a = exp_a + 32'd4;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
